// File: rtl/headgen_seq_ctrl_if.sv
// Bus bundle between the packet scheduler, the header mux and the egress byte
// stream. The egress side uses strict valid/ready: a byte transfers on a rising
// clock edge where out_valid and out_ready are both high; once out_valid rises,
// mux_sel, out_valid and out_last hold steady until that transfer happens, and
// out_valid never depends combinationally on out_ready.
interface headgen_seq_ctrl_if #(
  parameter int AW = 4
) ();
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [8:0]    cfg_data;
  logic [AW:0]   cfg_len;
  logic          start;
  logic [15:0]   fld_a;
  logic [15:0]   fld_b;
  logic          busy;
  logic [8:0]    mux_sel;
  logic [15:0]   mux_fld_a;
  logic [15:0]   mux_fld_b;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          hdr_done;

  // Scheduler / egress side.
  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_len, start, fld_a, fld_b, out_ready,
    input  busy, mux_sel, mux_fld_a, mux_fld_b, out_valid, out_last, hdr_done
  );

  // Sequencer side.
  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_len, start, fld_a, fld_b, out_ready,
    output busy, mux_sel, mux_fld_a, mux_fld_b, out_valid, out_last, hdr_done
  );
endinterface

// File: rtl/headgen_seq_ctrl.sv
// Header-generator sequencer: walks a programmable 9-bit template and drives
// the output mux select one entry per accepted egress byte. Every output is a
// flop; the FSM state is exposed on o_dbg_state.
module headgen_seq_ctrl #(
  parameter int HDR_MAX = 16,
  parameter int AW      = 4
) (
  input  logic                clk,
  input  logic                rst,
  headgen_seq_ctrl_if.slave   bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [AW:0] LP_MAX = (AW+1)'(HDR_MAX);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  logic [AW:0]   r_len, w_len_nxt;
  logic [8:0]    r_sel, w_sel_nxt;
  logic [15:0]   r_fa, w_fa_nxt;
  logic [15:0]   r_fb, w_fb_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_last, w_last_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic [8:0]    r_tmpl [HDR_MAX];

  logic [AW-1:0] w_ptr_inc;
  logic [AW:0]   w_len_m1;
  logic          w_at_end;
  logic          w_tmpl_wr;

  assign w_ptr_inc = r_ptr + AW'(1);
  assign w_len_m1  = r_len - (AW+1)'(1);
  assign w_at_end  = ({1'b0, r_ptr} == w_len_m1);
  // Writes only land while idle so a header always sees one stable template.
  assign w_tmpl_wr = bus.cfg_we && (r_state == S_IDLE) && !r_busy;

  // Template storage: cleared on reset, written only between headers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < HDR_MAX; i++) r_tmpl[i] <= '0;
    end else if (w_tmpl_wr) begin
      r_tmpl[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  // Next-state and next-output logic; every register holds unless a state says otherwise.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_len_nxt   = r_len;
    w_sel_nxt   = r_sel;
    w_fa_nxt    = r_fa;
    w_fb_nxt    = r_fb;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.cfg_len != '0)) begin
          w_len_nxt   = (bus.cfg_len > LP_MAX) ? LP_MAX : bus.cfg_len;
          w_fa_nxt    = bus.fld_a;
          w_fb_nxt    = bus.fld_b;
          w_ptr_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        // The template read here already includes a write accepted alongside start.
        w_sel_nxt   = r_tmpl[0];
        w_last_nxt  = (r_len == (AW+1)'(1));
        w_valid_nxt = 1'b1;
        w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (!w_at_end) begin
            w_ptr_nxt  = w_ptr_inc;
            w_sel_nxt  = r_tmpl[w_ptr_inc];
            w_last_nxt = ({1'b0, w_ptr_inc} == w_len_m1);
          end else begin
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any header in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_len   <= '0;
      r_sel   <= '0;
      r_fa    <= '0;
      r_fb    <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_len   <= w_len_nxt;
      r_sel   <= w_sel_nxt;
      r_fa    <= w_fa_nxt;
      r_fb    <= w_fb_nxt;
      r_valid <= w_valid_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.mux_sel   = r_sel;
  assign bus.mux_fld_a = r_fa;
  assign bus.mux_fld_b = r_fb;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.hdr_done  = r_done;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_headgen_seq_ctrl.sv
// Bench for headgen_seq_ctrl: a template model predicts every egress byte when
// start is driven; a negedge monitor pops and compares on each handshake.
module tb_headgen_seq_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  headgen_seq_ctrl_if #(.AW(4)) bus ();

  headgen_seq_ctrl #(.HDR_MAX(16), .AW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_hs     = 0;
  int          n_done   = 0;
  logic [17:0] exp_q[$];        // {last, mux_sel, byte}
  logic [7:0]  obs_q[$];
  logic [8:0]  last_sel;
  logic        last_flag;
  logic [8:0]  tmpl_m [16];

  logic        prev_valid, prev_ready, prev_last, prev_rst;
  logic [8:0]  prev_sel;

  // Model of the external mux fed by mux_sel and the latched fields.
  function automatic logic [7:0] mux_byte(input logic [8:0] sel, input logic [15:0] a, input logic [15:0] b);
    if (!sel[8]) return sel[7:0];
    case (sel[1:0])
      2'd0:    return a[15:8];
      2'd1:    return a[7:0];
      2'd2:    return b[15:8];
      default: return b[7:0];
    endcase
  endfunction

  // Monitor: sample between active edges, compare each handshake with the queue.
  always @(negedge clk) begin
    logic [7:0]  b;
    logic [17:0] e;
    if (rst === 1'b1 && prev_rst === 1'b1 && prev_valid === 1'b1 && prev_ready === 1'b0) begin
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.mux_sel !== prev_sel || bus.out_last !== prev_last) begin
        n_fail++;
        $display("FAIL stall_hold: valid=%b sel=%h last=%b, required valid=1 sel=%h last=%b",
                 bus.out_valid, bus.mux_sel, bus.out_last, prev_sel, prev_last);
      end
    end
    if (rst === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      n_hs++;
      b = mux_byte(bus.mux_sel, bus.mux_fld_a, bus.mux_fld_b);
      obs_q.push_back(b);
      last_sel  = bus.mux_sel;
      last_flag = bus.out_last;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_byte: sel=%h byte=%h last=%b, required no transfer", bus.mux_sel, b, bus.out_last);
      end else begin
        e = exp_q.pop_front();
        if ({bus.out_last, bus.mux_sel, b} !== e) begin
          n_fail++;
          $display("FAIL byte: last=%b sel=%h byte=%h, required last=%b sel=%h byte=%h",
                   bus.out_last, bus.mux_sel, b, e[17], e[16:8], e[7:0]);
        end
      end
    end
    if (bus.hdr_done === 1'b1) n_done++;
    prev_valid = bus.out_valid;
    prev_ready = bus.out_ready;
    prev_sel   = bus.mux_sel;
    prev_last  = bus.out_last;
    prev_rst   = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [8:0] data);
    bus.cfg_we   = 1'b1;
    bus.cfg_addr = addr;
    bus.cfg_data = data;
    tick();
    bus.cfg_we   = 1'b0;
    tmpl_m[addr] = data;
  endtask

  task automatic push_header(input logic [4:0] len, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = (len > 5'd16) ? 16 : int'(len);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), tmpl_m[i], mux_byte(tmpl_m[i], a, b)});
  endtask

  // mode 0: ready held high; mode 1: ready 1,0,0 repeating;
  // mode 2: ready high plus mid-header cfg write, start and fld_a change.
  task automatic run_header(input logic [4:0] len, input logic [15:0] a, input logic [15:0] b,
                            input int mode, output int busy_cyc, output int hs, output int dn);
    int d0, h0, cyc;
    d0 = n_done;
    h0 = n_hs;
    bus.start     = 1'b1;
    bus.cfg_len   = len;
    bus.fld_a     = a;
    bus.fld_b     = b;
    bus.out_ready = 1'b1;
    push_header(len, a, b);
    tick();
    bus.start = 1'b0;
    busy_cyc  = 0;
    cyc       = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      busy_cyc++;
      bus.out_ready = (mode == 1) ? ((cyc % 3) == 1) : 1'b1;
      if (mode == 2 && cyc == 2) begin
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'd0;
        bus.cfg_data = 9'h0FF;
        bus.start    = 1'b1;
        bus.cfg_len  = 5'd3;
        bus.fld_a    = 16'hFFFF;
      end
      if (mode == 2 && cyc == 3) begin
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
      end
      if (mode == 2 && cyc == 4) begin
        n_checks++;
        if (bus.mux_fld_a !== a) begin
          n_fail++;
          $display("FAIL fld_a_latched: mux_fld_a=%h, required %h", bus.mux_fld_a, a);
        end
      end
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc >= 200) begin
      n_fail++;
      $display("FAIL header_timeout: busy still %b after %0d cycles, required busy=0", bus.busy, cyc);
    end
    n_checks++;
    if (bus.hdr_done !== (len != 5'd0)) begin
      n_fail++;
      $display("FAIL done_at_busy_fall: hdr_done=%b, required %b", bus.hdr_done, (len != 5'd0));
    end
    bus.out_ready = 1'b1;
    tick();
    dn = n_done - d0;
    hs = n_hs - h0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy: %b, required 0", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_valid: %b, required 0", bus.out_valid); end
    n_checks++; if (bus.out_last !== 1'b0)      begin n_fail++; $display("FAIL rst_last: %b, required 0", bus.out_last); end
    n_checks++; if (bus.hdr_done !== 1'b0)      begin n_fail++; $display("FAIL rst_done: %b, required 0", bus.hdr_done); end
    n_checks++; if (bus.mux_sel !== 9'h000)     begin n_fail++; $display("FAIL rst_sel: %h, required 000", bus.mux_sel); end
    n_checks++; if (bus.mux_fld_a !== 16'h0000) begin n_fail++; $display("FAIL rst_fld_a: %h, required 0000", bus.mux_fld_a); end
    n_checks++; if (bus.mux_fld_b !== 16'h0000) begin n_fail++; $display("FAIL rst_fld_b: %h, required 0000", bus.mux_fld_b); end
    n_checks++; if (dbg_state !== 2'd0)         begin n_fail++; $display("FAIL rst_state: %0d, required 0", dbg_state); end
    rst = 1'b1;
    tick();
  endtask

  task automatic load_tmpl_basic();
    logic [8:0] t [7];
    t = '{9'h001, 9'h002, 9'h003, 9'h100, 9'h101, 9'h102, 9'h103};
    for (int i = 0; i < 7; i++) cfg_write(4'(i), t[i]);
  endtask

  task automatic test_basic();
    int bc, hs, dn;
    load_tmpl_basic();
    obs_q.delete();
    run_header(5'd7, 16'h0405, 16'h0607, 0, bc, hs, dn);
    n_checks++; if (bc !== 9) begin n_fail++; $display("FAIL basic_busy_cycles: %0d, required 9", bc); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL basic_done_pulses: %0d, required 1", dn); end
    n_checks++; if (hs !== 7) begin n_fail++; $display("FAIL basic_handshakes: %0d, required 7", hs); end
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL basic_byte%0d: %h, required %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, 8'(i + 1));
      end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_leftover: %0d bytes, required 0", exp_q.size()); end
  endtask

  task automatic test_field_select();
    int bc, hs, dn;
    logic [8:0] t [5];
    logic [7:0] want [5];
    t    = '{9'h0A1, 9'h100, 9'h101, 9'h102, 9'h107};
    want = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
    for (int i = 0; i < 5; i++) cfg_write(4'(i), t[i]);
    obs_q.delete();
    run_header(5'd5, 16'hB2C3, 16'hD4E5, 0, bc, hs, dn);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== want[i]) begin
        n_fail++;
        $display("FAIL field_byte%0d: %h, required %h", i, (i < obs_q.size()) ? obs_q[i] : 8'hxx, want[i]);
      end
    end
    n_checks++; if (last_sel !== 9'h107) begin n_fail++; $display("FAIL field_last_sel: %h, required 107", last_sel); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL field_done_pulses: %0d, required 1", dn); end
  endtask

  task automatic test_stall();
    int bc, hs, dn;
    load_tmpl_basic();
    run_header(5'd7, 16'h0405, 16'h0607, 1, bc, hs, dn);
    n_checks++; if (hs !== 7) begin n_fail++; $display("FAIL stall_handshakes: %0d, required 7", hs); end
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL stall_done_pulses: %0d, required 1", dn); end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_leftover: %0d bytes, required 0", exp_q.size()); end
  endtask

  task automatic test_mid_header();
    int bc, hs, dn;
    run_header(5'd7, 16'h0405, 16'h0607, 2, bc, hs, dn);
    n_checks++; if (dn !== 1) begin n_fail++; $display("FAIL mid_done_pulses: %0d, required 1", dn); end
    n_checks++; if (hs !== 7) begin n_fail++; $display("FAIL mid_handshakes: %0d, required 7", hs); end
    obs_q.delete();
    run_header(5'd7, 16'h0405, 16'h0607, 0, bc, hs, dn);
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0] !== 8'h01) begin
      n_fail++;
      $display("FAIL mid_tmpl_kept: first byte %h, required 01", (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
    end
  endtask

  task automatic test_boundaries();
    int bc, hs, dn;
    run_header(5'd0, 16'h1111, 16'h2222, 0, bc, hs, dn);
    n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL len0_busy: %0d cycles, required 0", bc); end
    n_checks++; if (hs !== 0 || dn !== 0) begin n_fail++; $display("FAIL len0_activity: hs=%0d done=%0d, required 0 0", hs, dn); end
    run_header(5'd1, 16'h1111, 16'h2222, 0, bc, hs, dn);
    n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL len1_handshakes: %0d, required 1", hs); end
    n_checks++; if (last_flag !== 1'b1) begin n_fail++; $display("FAIL len1_last: %b, required 1", last_flag); end
    n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL len1_busy: %0d cycles, required 3", bc); end
    run_header(5'd20, 16'h3344, 16'h5566, 0, bc, hs, dn);
    n_checks++; if (hs !== 16) begin n_fail++; $display("FAIL len20_clamp: %0d bytes, required 16", hs); end
    n_checks++; if (bc !== 18) begin n_fail++; $display("FAIL len20_busy: %0d cycles, required 18", bc); end
  endtask

  task automatic test_reset_mid();
    int bc, hs, dn, d0, h0;
    d0 = n_done;
    h0 = n_hs;
    bus.start     = 1'b1;
    bus.cfg_len   = 5'd7;
    bus.fld_a     = 16'h0405;
    bus.fld_b     = 16'h0607;
    bus.out_ready = 1'b1;
    push_header(5'd7, 16'h0405, 16'h0607);
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    // third byte is on the bus now; withhold ready and reset instead
    n_checks++; if (n_hs - h0 !== 2) begin n_fail++; $display("FAIL rmid_pre_hs: %0d, required 2", n_hs - h0); end
    bus.out_ready = 1'b0;
    rst = 1'b0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: %b, required 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL rmid_busy: %b, required 0", bus.busy); end
    n_checks++; if (bus.mux_sel !== 9'h000) begin n_fail++; $display("FAIL rmid_sel: %h, required 000", bus.mux_sel); end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    n_checks++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL rmid_no_done: %0d pulses, required 0", n_done - d0); end
    n_checks++; if (exp_q.size() != 5) begin n_fail++; $display("FAIL rmid_pending: %0d, required 5", exp_q.size()); end
    exp_q.delete();
    for (int i = 0; i < 16; i++) tmpl_m[i] = 9'h000;
    obs_q.delete();
    run_header(5'd2, 16'h1234, 16'h5678, 0, bc, hs, dn);
    n_checks++;
    if (obs_q.size() != 2 || obs_q[0] !== 8'h00 || obs_q[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_tmpl_cleared: %0d bytes first=%h, required 2 bytes 00 00",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst           = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.cfg_len   = '0;
    bus.start     = 1'b0;
    bus.fld_a     = '0;
    bus.fld_b     = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) tmpl_m[i] = 9'h000;

    test_reset();
    test_basic();
    test_field_select();
    test_stall();
    test_mid_header();
    test_boundaries();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
